// File: rtl/button_gesture_decoder_if.sv
// Debouncer-side events in, classified gesture pulses out.
// The periodic pulse is named auto_repeat because `repeat` is a reserved word.
interface button_gesture_decoder_if;
  logic button_state;
  logic button_down;
  logic button_up;
  logic short_press;
  logic double_click;
  logic long_press;
  logic auto_repeat;
  logic held;

  modport master (
    output button_state, button_down, button_up,
    input  short_press, double_click, long_press, auto_repeat, held
  );

  modport slave (
    input  button_state, button_down, button_up,
    output short_press, double_click, long_press, auto_repeat, held
  );
endinterface

// File: rtl/button_gesture_decoder.sv
// Classifies debounced button events into short press, double click,
// long press and auto-repeat; all outputs are registered.
module button_gesture_decoder #(
  parameter int unsigned LONG_CYCLES   = 25_000_000,
  parameter int unsigned REPEAT_CYCLES = 5_000_000,
  parameter int unsigned DOUBLE_CYCLES = 12_500_000,
  parameter int unsigned CNT_W         = 25
) (
  input logic                    clk,
  input logic                    rst_n,
  button_gesture_decoder_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRESSED, S_WAIT2, S_PRESSED2, S_HELD
  } state_t;

  localparam logic [CNT_W-1:0] LONG_M1 = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_M1  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DBL_M1  = CNT_W'(DOUBLE_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             short_q, dbl_q, long_q, rpt_q, held_q, dbl_pend;
  logic             dn, up, rel;

  // Simultaneous down+up cancel each other; a low level also releases,
  // covering a lost button_up pulse.
  always_comb begin
    dn  = bus.button_down & ~bus.button_up;
    up  = bus.button_up & ~bus.button_down;
    rel = up | ~bus.button_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      short_q  <= 1'b0;
      dbl_q    <= 1'b0;
      long_q   <= 1'b0;
      rpt_q    <= 1'b0;
      held_q   <= 1'b0;
      dbl_pend <= 1'b0;
    end else begin
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      rpt_q    <= 1'b0;
      // double_click lands one cycle after the sampled second release
      dbl_q    <= dbl_pend;
      dbl_pend <= 1'b0;
      // held stays up through the releasing edge and drops the cycle after
      held_q   <= (state == S_HELD);
      case (state)
        S_IDLE: begin
          if (dn) begin
            state <= S_PRESSED;
            cnt   <= '0;
          end
        end
        S_PRESSED: begin
          if (rel) begin
            state <= S_WAIT2;
            cnt   <= '0;
          end else if (cnt == LONG_M1) begin
            long_q <= 1'b1;
            held_q <= 1'b1;
            state  <= S_HELD;
            cnt    <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_HELD: begin
          if (rel) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (cnt == REP_M1) begin
            rpt_q <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_WAIT2: begin
          if (dn) begin
            state <= S_PRESSED2;
            cnt   <= '0;
          end else if (cnt == DBL_M1) begin
            short_q <= 1'b1;
            state   <= S_IDLE;
            cnt     <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_PRESSED2: begin
          if (rel) begin
            dbl_pend <= 1'b1;
            state    <= S_IDLE;
            cnt      <= '0;
          end else if (cnt == LONG_M1) begin
            // first click was a short press, the second became a hold
            short_q <= 1'b1;
            long_q  <= 1'b1;
            held_q  <= 1'b1;
            state   <= S_HELD;
            cnt     <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.short_press  = short_q;
  assign bus.double_click = dbl_q;
  assign bus.long_press   = long_q;
  assign bus.auto_repeat  = rpt_q;
  assign bus.held         = held_q;

endmodule

// File: tb/tb_button_gesture_decoder.sv
// Gesture-level reference model: each press/release script is turned into
// expected pulse times by arithmetic on the thresholds, then compared per cycle.
module tb_button_gesture_decoder;
  localparam int L = 8, R = 4, D = 6, W = 4, SLOT = 64;
  localparam logic [4:0] SP = 5'b00001, DC = 5'b00010, LP = 5'b00100,
                         RP = 5'b01000, HD = 5'b10000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  button_gesture_decoder_if bus();

  button_gesture_decoder #(
    .LONG_CYCLES(L), .REPEAT_CYCLES(R), .DOUBLE_CYCLES(D), .CNT_W(W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_pass = 0, n_total = 0;
  logic       st_s[SLOT], st_d[SLOT], st_u[SLOT];
  logic [4:0] exp_v[SLOT], obs_v[SLOT];

  function automatic logic [4:0] outs();
    return {bus.held, bus.auto_repeat, bus.long_press, bus.double_click, bus.short_press};
  endfunction

  task automatic press(input int d, input int u, input logic lose);
    st_d[d] = 1'b1;
    for (int c = d; c < u; c++) st_s[c] = 1'b1;
    st_u[u] = ~lose;
  endtask

  // long at t_long, held through the release edge, repeats strictly before it
  task automatic mark_hold(input int t_long, input int t_rel, input logic with_short);
    exp_v[t_long] |= LP | (with_short ? SP : 5'b0);
    for (int c = t_long; c <= t_rel; c++) exp_v[c] |= HD;
    for (int t = t_long + R; t < t_rel; t += R) exp_v[t] |= RP;
  endtask

  // Gesture: press p1, optional second press after gap g (g <= D) lasting p2.
  task automatic build(input int p1, input logic two, input int g, input int p2, input logic lose);
    int d1, u1, d2, u2;
    for (int c = 0; c < SLOT; c++) begin
      st_s[c] = 1'b0; st_d[c] = 1'b0; st_u[c] = 1'b0; exp_v[c] = '0;
    end
    d1 = 2; u1 = d1 + p1;
    press(d1, u1, lose);
    if (p1 > L) mark_hold(d1 + L, u1, 1'b0);
    else if (two) begin
      d2 = u1 + g; u2 = d2 + p2;
      press(d2, u2, lose);
      if (p2 > L) mark_hold(d2 + L, u2, 1'b1);
      else exp_v[u2 + 1] |= DC;
    end else exp_v[u1 + D] |= SP;
  endtask

  task automatic drive();
    for (int c = 0; c < SLOT; c++) begin
      bus.button_state = st_s[c];
      bus.button_down  = st_d[c];
      bus.button_up    = st_u[c];
      @(posedge clk); #1;
      obs_v[c] = outs();
    end
    bus.button_state = 1'b0; bus.button_down = 1'b0; bus.button_up = 1'b0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 4; c++) begin
      bus.button_state = 1'($urandom); bus.button_down = 1'($urandom); bus.button_up = 1'($urandom);
      @(posedge clk); #1;
      n_total++;
      if (outs() !== 5'b0) $display("FAIL reset cyc %0d got %b exp %b", c, outs(), 5'b0);
      else n_pass++;
    end
    bus.button_state = 1'b0; bus.button_down = 1'b0; bus.button_up = 1'b1;
    #2 rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      bus.button_up = 1'b0;
      n_total++;
      if (outs() !== 5'b0) $display("FAIL reset_idle cyc %0d got %b exp %b", c, outs(), 5'b0);
      else n_pass++;
    end
  endtask

  task automatic test_short_press();
    build(3, 1'b0, 0, 0, 1'b0); drive();
    for (int c = 0; c < SLOT; c++) begin
      n_total++;
      if (obs_v[c] !== exp_v[c]) $display("FAIL short_press cyc %0d got %b exp %b", c, obs_v[c], exp_v[c]);
      else n_pass++;
    end
  endtask

  task automatic test_double_click();
    build(2, 1'b1, 3, 2, 1'b0); drive();
    for (int c = 0; c < SLOT; c++) begin
      n_total++;
      if (obs_v[c] !== exp_v[c]) $display("FAIL double_click cyc %0d got %b exp %b", c, obs_v[c], exp_v[c]);
      else n_pass++;
    end
  endtask

  task automatic test_hold_repeat();
    build(30, 1'b0, 0, 0, 1'b0); drive();
    for (int c = 0; c < SLOT; c++) begin
      n_total++;
      if (obs_v[c] !== exp_v[c]) $display("FAIL hold_repeat cyc %0d got %b exp %b", c, obs_v[c], exp_v[c]);
      else n_pass++;
    end
  endtask

  task automatic test_threshold_race();
    build(L, 1'b0, 0, 0, 1'b0); drive();
    for (int c = 0; c < SLOT; c++) begin
      n_total++;
      if (obs_v[c] !== exp_v[c]) $display("FAIL threshold_race cyc %0d got %b exp %b", c, obs_v[c], exp_v[c]);
      else n_pass++;
    end
  endtask

  task automatic test_second_click_held();
    build(2, 1'b1, 2, 14, 1'b0); drive();
    for (int c = 0; c < SLOT; c++) begin
      n_total++;
      if (obs_v[c] !== exp_v[c]) $display("FAIL second_held cyc %0d got %b exp %b", c, obs_v[c], exp_v[c]);
      else n_pass++;
    end
  endtask

  // down+up in the same cycle must be ignored, both mid-hold and while idle
  task automatic test_simultaneous();
    build(12, 1'b0, 0, 0, 1'b0);
    st_d[5] = 1'b1; st_u[5] = 1'b1;
    st_d[40] = 1'b1; st_u[40] = 1'b1;
    drive();
    for (int c = 0; c < SLOT; c++) begin
      n_total++;
      if (obs_v[c] !== exp_v[c]) $display("FAIL simultaneous cyc %0d got %b exp %b", c, obs_v[c], exp_v[c]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int p1, g, p2;
    logic two, lose;
    for (int n = 0; n < 20; n++) begin
      p1   = int'($urandom_range(1, 20));
      two  = 1'($urandom);
      g    = int'($urandom_range(1, D));
      p2   = int'($urandom_range(1, 20));
      lose = ($urandom_range(0, 3) == 0);
      build(p1, two, g, p2, lose); drive();
      for (int c = 0; c < SLOT; c++) begin
        n_total++;
        if (obs_v[c] !== exp_v[c])
          $display("FAIL random g%0d(p1=%0d two=%0d g=%0d p2=%0d lose=%0d) cyc %0d got %b exp %b",
                   n, p1, two, g, p2, lose, c, obs_v[c], exp_v[c]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [4:0] e;
    for (int c = 0; c <= 41; c++) begin
      bus.button_down  = (c == 0) || (c == 20);
      bus.button_up    = (c == 15);
      bus.button_state = (c < 15) || (c >= 20);
      @(posedge clk); #1;
      if (c == 10) rst_n = 1'b0;
      #1;
      e = '0;
      if (c == 8) e = LP | HD;
      if (c == 9) e = HD;
      if (c >= 28) begin
        e = HD;
        if (c == 28) e |= LP;
        if (c > 28 && (c - 28) % R == 0) e |= RP;
      end
      n_total++;
      if (outs() !== e) $display("FAIL reset_mid_hold cyc %0d got %b exp %b", c, outs(), e);
      else n_pass++;
      if (c == 11) rst_n = 1'b1;
    end
    bus.button_down = 1'b0; bus.button_up = 1'b1; bus.button_state = 1'b0;
    @(posedge clk); #1;
    bus.button_up = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    bus.button_state = 1'b0; bus.button_down = 1'b0; bus.button_up = 1'b0;
    test_reset();
    test_short_press();
    test_double_click();
    test_hold_repeat();
    test_threshold_race();
    test_second_click_held();
    test_simultaneous();
    test_random();
    test_reset_mid_hold();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
